// File: rtl/mesh_rect_engine_if.sv
// Operand/result bus of the rectangular systolic engine: job control,
// skewed-in operand beats and the row-by-row result handshake.
interface mesh_rect_engine_if #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_MAX      = 256,
  parameter int KW         = $clog2(K_MAX + 1),
  parameter int RW         = (ROWS > 1) ? $clog2(ROWS) : 1
);

  logic                                 start_i;
  logic [KW-1:0]                        k_len_i;
  logic                                 accumulate_i;
  logic [0:ROWS-1][DATA_WIDTH-1:0]      west_i;
  logic [0:COLS-1][DATA_WIDTH-1:0]      north_i;
  logic                                 in_valid_i;
  logic                                 in_ready_o;
  logic [0:COLS-1][ACC_WIDTH-1:0]       result_o;
  logic [RW-1:0]                        result_row_o;
  logic                                 result_valid_o;
  logic                                 result_ready_i;
  logic                                 busy_o;
  logic                                 done_o;

  modport master (
    output start_i, k_len_i, accumulate_i, west_i, north_i, in_valid_i,
    output result_ready_i,
    input  in_ready_o, result_o, result_row_o, result_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, k_len_i, accumulate_i, west_i, north_i, in_valid_i,
    input  result_ready_i,
    output in_ready_o, result_o, result_row_o, result_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/mesh_rect_engine.sv
// ROWS x COLS output-stationary systolic matrix multiplier. A enters from
// the west and B from the north through per-lane skew lines, each cell keeps
// its own signed accumulator, and a job FSM loads K beats, flushes the
// wavefront out of the mesh and then hands the result out one row at a time.
module mesh_rect_engine #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter int K_MAX      = 256,
  parameter int KW         = $clog2(K_MAX + 1)
) (
  input logic              clk_i,
  input logic              rst_i,
  mesh_rect_engine_if.slave bus
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FW = $clog2(ROWS + COLS + 1);
  localparam logic [FW-1:0] FLUSH_INIT = FW'(ROWS + COLS - 2);
  localparam logic [KW-1:0] K_LIMIT    = KW'(K_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [KW-1:0] k_q, beat_q, k_eff;
  logic [FW-1:0] flush_q;
  logic [RW-1:0] row_q;

  logic accept, clear_acc, load_job, enter_flush, row_adv;

  logic signed [DATA_WIDTH-1:0] west_d  [ROWS];
  logic                         west_dv [ROWS];
  logic signed [DATA_WIDTH-1:0] north_d  [COLS];
  logic                         north_dv [COLS];

  logic signed [DATA_WIDTH-1:0] a_q   [ROWS][COLS];
  logic                         av_q  [ROWS][COLS];
  logic signed [DATA_WIDTH-1:0] b_q   [ROWS][COLS];
  logic                         bv_q  [ROWS][COLS];
  logic signed [ACC_WIDTH-1:0]  acc_q [ROWS][COLS];

  // Sign-extend both operands to the accumulator width before multiplying,
  // so the low ACC_WIDTH bits give the product modulo 2^ACC_WIDTH.
  function automatic logic signed [ACC_WIDTH-1:0] mac_term(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH-1:0] ax;
    logic signed [ACC_WIDTH-1:0] bx;
    ax = ACC_WIDTH'(a);
    bx = ACC_WIDTH'(b);
    return ax * bx;
  endfunction

  assign k_eff = (bus.k_len_i > K_LIMIT) ? K_LIMIT : bus.k_len_i;

  // West skew: row r is delayed r cycles so it meets column data diagonally.
  for (genvar r = 0; r < ROWS; r++) begin : g_west
    if (r == 0) begin : g_pass
      assign west_d[r]  = bus.west_i[r];
      assign west_dv[r] = accept;
    end else begin : g_dly
      logic [r-1:0][DATA_WIDTH-1:0] data_sr;
      logic [r-1:0]                 vld_sr;
      // Shift row r's operand and its valid tag down a depth-r delay line.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          data_sr <= '0;
          vld_sr  <= '0;
        end else begin
          data_sr[0] <= bus.west_i[r];
          vld_sr[0]  <= accept;
          for (int i = 1; i < r; i++) begin
            data_sr[i] <= data_sr[i-1];
            vld_sr[i]  <= vld_sr[i-1];
          end
        end
      end
      assign west_d[r]  = data_sr[r-1];
      assign west_dv[r] = vld_sr[r-1];
    end
  end

  // North skew: column c is delayed c cycles.
  for (genvar c = 0; c < COLS; c++) begin : g_north
    if (c == 0) begin : g_pass
      assign north_d[c]  = bus.north_i[c];
      assign north_dv[c] = accept;
    end else begin : g_dly
      logic [c-1:0][DATA_WIDTH-1:0] data_sr;
      logic [c-1:0]                 vld_sr;
      // Shift column c's operand and its valid tag down a depth-c delay line.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          data_sr <= '0;
          vld_sr  <= '0;
        end else begin
          data_sr[0] <= bus.north_i[c];
          vld_sr[0]  <= accept;
          for (int i = 1; i < c; i++) begin
            data_sr[i] <= data_sr[i-1];
            vld_sr[i]  <= vld_sr[i-1];
          end
        end
      end
      assign north_d[c]  = data_sr[c-1];
      assign north_dv[c] = vld_sr[c-1];
    end
  end

  // Move A one cell east and B one cell south per cycle, tags travelling along.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          a_q[r][c]  <= '0;
          av_q[r][c] <= 1'b0;
          b_q[r][c]  <= '0;
          bv_q[r][c] <= 1'b0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        a_q[r][0]  <= west_d[r];
        av_q[r][0] <= west_dv[r];
        for (int c = 1; c < COLS; c++) begin
          a_q[r][c]  <= a_q[r][c-1];
          av_q[r][c] <= av_q[r][c-1];
        end
      end
      for (int c = 0; c < COLS; c++) begin
        b_q[0][c]  <= north_d[c];
        bv_q[0][c] <= north_dv[c];
        for (int r = 1; r < ROWS; r++) begin
          b_q[r][c]  <= b_q[r-1][c];
          bv_q[r][c] <= bv_q[r-1][c];
        end
      end
    end
  end

  // Each cell accumulates only when both operands it holds are tagged valid;
  // a fresh job without accumulate wipes every accumulator first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          acc_q[r][c] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if (clear_acc)
            acc_q[r][c] <= '0;
          else if (av_q[r][c] && bv_q[r][c])
            acc_q[r][c] <= acc_q[r][c] + mac_term(a_q[r][c], b_q[r][c]);
        end
      end
    end
  end

  // Job state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Job bookkeeping: latched K, accepted-beat count, flush countdown, drain row.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_q     <= '0;
      beat_q  <= '0;
      flush_q <= '0;
      row_q   <= '0;
    end else begin
      if (load_job) begin
        k_q    <= k_eff;
        beat_q <= '0;
      end else if (accept) begin
        beat_q <= beat_q + KW'(1);
      end
      if (enter_flush)
        flush_q <= FLUSH_INIT;
      else if (state_q == S_FLUSH && flush_q != '0)
        flush_q <= flush_q - FW'(1);
      if (row_adv)
        row_q <= (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
    end
  end

  // Next-state decode and the handshake/status outputs derived from state.
  always_comb begin
    state_d            = state_q;
    accept             = 1'b0;
    clear_acc          = 1'b0;
    load_job           = 1'b0;
    enter_flush        = 1'b0;
    row_adv            = 1'b0;
    bus.in_ready_o     = 1'b0;
    bus.result_valid_o = 1'b0;
    bus.result_row_o   = '0;
    bus.done_o         = 1'b0;
    bus.busy_o         = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          load_job  = 1'b1;
          clear_acc = !bus.accumulate_i;
          state_d   = (k_eff == '0) ? S_DRAIN : S_LOAD;
        end
      end
      S_LOAD: begin
        bus.in_ready_o = 1'b1;
        accept         = bus.in_valid_i;
        if (accept && beat_q == k_q - KW'(1)) begin
          enter_flush = 1'b1;
          state_d     = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (flush_q == '0) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        bus.result_valid_o = 1'b1;
        bus.result_row_o   = row_q;
        if (bus.result_ready_i) begin
          row_adv = 1'b1;
          if (row_q == RW'(ROWS - 1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        bus.done_o = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Present the accumulator row being drained; zeros at all other times.
  always_comb begin
    bus.result_o = '0;
    if (state_q == S_DRAIN) begin
      for (int c = 0; c < COLS; c++)
        bus.result_o[c] = acc_q[row_q][c];
    end
  end

endmodule
